// File: rtl/radiant_trig_coinc_pkg.sv
// Shared constants, FSM state type and popcount helper for the RADIANT
// coincidence trigger.
package radiant_trig_pkg;

  localparam int NCHAN    = 24;
  localparam int WIN_BITS = 7;
  localparam int CNT_BITS = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } coinc_state_e;

  function automatic logic [CNT_BITS-1:0] popcount(input logic [NCHAN-1:0] v);
    logic [CNT_BITS-1:0] w_sum;
    w_sum = {CNT_BITS{1'b0}};
    for (int i = 0; i < NCHAN; i++) begin
      w_sum = w_sum + {{(CNT_BITS-1){1'b0}}, v[i]};
    end
    return w_sum;
  endfunction

endpackage

// File: rtl/radiant_trig_coinc_if.sv
// Configuration, trigger inputs and trigger results of the coincidence block.
interface radiant_trig_coinc_if #(
  parameter int NCHAN    = radiant_trig_pkg::NCHAN,
  parameter int WIN_BITS = radiant_trig_pkg::WIN_BITS
);
  logic [NCHAN-1:0]    i_trig;
  logic [NCHAN-1:0]    i_trig_en;
  logic [NCHAN-1:0]    i_include;
  logic [WIN_BITS-1:0] i_window;
  logic [4:0]          i_thresh;
  logic                i_enable;
  logic                i_inhibit;
  logic                o_trig;
  logic [NCHAN-1:0]    o_chan;
  logic [4:0]          o_count;

  modport master (
    output i_trig, i_trig_en, i_include, i_window, i_thresh, i_enable, i_inhibit,
    input  o_trig, o_chan, o_count
  );

  modport slave (
    input  i_trig, i_trig_en, i_include, i_window, i_thresh, i_enable, i_inhibit,
    output o_trig, o_chan, o_count
  );
endinterface

// File: rtl/radiant_trig_coinc_stretch.sv
// Per-channel rising-edge detector feeding a reloadable down-counter that
// holds the channel active for window+1 clocks.
module radiant_trig_stretch #(
  parameter int WIN_BITS = radiant_trig_pkg::WIN_BITS
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                srst,
  input  logic                i_enable,
  input  logic                i_trig,
  input  logic                i_qual,
  input  logic [WIN_BITS-1:0] i_window,
  output logic                o_stretch
);

  logic                r_prev;
  logic                r_armed;
  logic [WIN_BITS:0]   r_cnt;
  logic [WIN_BITS:0]   w_cnt_nxt;
  logic                w_edge;

  // r_armed masks the first cycle after reset so a level already high is not an edge
  assign w_edge    = i_trig & ~r_prev & r_armed;
  assign o_stretch = |r_cnt;

  // Counter next state: clear, reload on edge, or count down
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_enable || !i_qual) begin
      w_cnt_nxt = {(WIN_BITS+1){1'b0}};
    end else if (w_edge) begin
      w_cnt_nxt = {1'b0, i_window} + {{WIN_BITS{1'b0}}, 1'b1};
    end else if (r_cnt != {(WIN_BITS+1){1'b0}}) begin
      w_cnt_nxt = r_cnt - {{WIN_BITS{1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Edge history and stretch counter registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= {(WIN_BITS+1){1'b0}};
    end else if (srst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= {(WIN_BITS+1){1'b0}};
    end else begin
      r_prev  <= i_trig;
      r_armed <= 1'b1;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/radiant_trig_coinc.sv
// N-channel coincidence trigger: stretched channel levels are counted and a
// single trigger pulse is issued when the count exceeds the threshold.
module radiant_trig_coinc
  import radiant_trig_pkg::coinc_state_e;
  import radiant_trig_pkg::ST_IDLE;
  import radiant_trig_pkg::ST_HOLD;
  import radiant_trig_pkg::popcount;
#(
  parameter int NCHAN    = radiant_trig_pkg::NCHAN,
  parameter int WIN_BITS = radiant_trig_pkg::WIN_BITS
) (
  input logic                  clk,
  input logic                  rst_b,
  input logic                  srst,
  radiant_trig_coinc_if.slave  bus
);

  logic [NCHAN-1:0] w_qual;
  logic [NCHAN-1:0] w_stretch;
  logic [NCHAN-1:0] r_pat;
  logic [4:0]       r_count;
  logic [NCHAN-1:0] r_chan;
  logic             r_trig;
  coinc_state_e     r_state;
  coinc_state_e     w_state_nxt;
  logic             w_fire;

  assign w_qual = bus.i_trig_en & bus.i_include;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    radiant_trig_stretch #(.WIN_BITS(WIN_BITS)) u_stretch (
      .clk       (clk),
      .rst_b     (rst_b),
      .srst      (srst),
      .i_enable  (bus.i_enable),
      .i_trig    (bus.i_trig[g]),
      .i_qual    (w_qual[g]),
      .i_window  (bus.i_window),
      .o_stretch (w_stretch[g])
    );
  end

  // r_pat is kept alongside r_count so chan_o captures the pattern the count was taken from
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pat   <= {NCHAN{1'b0}};
      r_count <= 5'd0;
    end else if (srst || !bus.i_enable) begin
      r_pat   <= {NCHAN{1'b0}};
      r_count <= 5'd0;
    end else begin
      r_pat   <= w_stretch;
      r_count <= popcount(w_stretch);
    end
  end

  // Trigger FSM next state and fire decision
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    if (!bus.i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((r_count > bus.i_thresh) && !bus.i_inhibit) begin
            w_fire      = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (r_count == 5'd0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state, trigger pulse and captured channel pattern
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_trig  <= 1'b0;
      r_chan  <= {NCHAN{1'b0}};
    end else if (srst) begin
      r_state <= ST_IDLE;
      r_trig  <= 1'b0;
      r_chan  <= {NCHAN{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_trig  <= w_fire;
      if (w_fire) begin
        r_chan <= r_pat;
      end else begin
        r_chan <= r_chan;
      end
    end
  end

  assign bus.o_trig  = r_trig;
  assign bus.o_chan  = r_chan;
  assign bus.o_count = r_count;

endmodule

// File: tb/tb_radiant_trig_coinc.sv
// Directed, table-driven bench for radiant_trig_coinc with hand-written
// sequences for inhibit, reset, enable and mask-change corner cases.
module tb_radiant_trig_coinc;

  localparam int RUN_LEN = 300;

  logic clk;
  logic rst_b;
  logic srst;

  radiant_trig_coinc_if u_if ();

  radiant_trig_coinc u_dut (
    .clk   (clk),
    .rst_b (rst_b),
    .srst  (srst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  typedef struct {
    logic [6:0]  win;
    logic [4:0]  thr;
    logic [23:0] en;
    logic [23:0] inc;
    int          c0;
    logic [23:0] m0;
    int          c1;
    logic [23:0] m1;
    int          c2;
    logic [23:0] m2;
    int          c3;
    logic [23:0] m3;
    int          exp_n;
    int          exp_cyc;
    logic [23:0] exp_chan;
    logic [4:0]  exp_cnt;
    logic [4:0]  exp_peak;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n, output int ntrig);
    ntrig = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (u_if.o_trig) ntrig++;
    end
  endtask

  task automatic set_cfg(input logic [6:0] win, input logic [4:0] thr,
                         input logic [23:0] en, input logic [23:0] inc);
    u_if.i_window  = win;
    u_if.i_thresh  = thr;
    u_if.i_trig_en = en;
    u_if.i_include = inc;
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    int          n;
    int          tcyc;
    logic [23:0] tchan;
    logic [4:0]  tcnt;
    logic [4:0]  peak;
    logic [23:0] m;
    v     = vecs[idx];
    n     = 0;
    tcyc  = -1;
    tchan = 24'h0;
    tcnt  = 5'd0;
    peak  = 5'd0;
    set_cfg(v.win, v.thr, v.en, v.inc);
    for (int cyc = 0; cyc < RUN_LEN; cyc++) begin
      m = 24'h0;
      if (v.c0 == cyc) m = m | v.m0;
      if (v.c1 == cyc) m = m | v.m1;
      if (v.c2 == cyc) m = m | v.m2;
      if (v.c3 == cyc) m = m | v.m3;
      u_if.i_trig = m;
      tick();
      if (u_if.o_trig) begin
        n++;
        if (n == 1) begin
          tcyc  = cyc;
          tchan = u_if.o_chan;
          tcnt  = u_if.o_count;
        end
      end
      if (u_if.o_count > peak) peak = u_if.o_count;
    end
    u_if.i_trig = 24'h0;
    chk($sformatf("v%0d trig_count", idx), 32'(n), 32'(v.exp_n));
    chk($sformatf("v%0d count_peak", idx), 32'(peak), 32'(v.exp_peak));
    chk($sformatf("v%0d count_end", idx), 32'(u_if.o_count), 32'd0);
    if (v.exp_n == 1) begin
      chk($sformatf("v%0d trig_cycle", idx), 32'(tcyc), 32'(v.exp_cyc));
      chk($sformatf("v%0d chan_o", idx), 32'(tchan), 32'(v.exp_chan));
      chk($sformatf("v%0d count_at_trig", idx), 32'(tcnt), 32'(v.exp_cnt));
    end
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;

    //          win    thr    en          inc         c0 m0          c1   m1          c2  m2        c3  m3     n  cyc  chan        cnt    peak
    vecs[0]  = '{7'd73, 5'd2, 24'hFFFFFF, 24'hFFFFFF, 0, 24'h000001, 10, 24'h000002, 20, 24'h4,  -1, 24'h0, 1, 22,  24'h000007, 5'd3,  5'd3};
    vecs[1]  = '{7'd73, 5'd2, 24'hFFFFFF, 24'hFFFFFF, 0, 24'h000001, 10, 24'h000002, 80, 24'h4,  -1, 24'h0, 0, 0,   24'h000000, 5'd0,  5'd2};
    vecs[2]  = '{7'd73, 5'd2, 24'hFFFFFF, 24'hFFFFFE, 0, 24'h000001, 5,  24'h000002, 10, 24'h4,  -1, 24'h0, 0, 0,   24'h000000, 5'd0,  5'd2};
    vecs[3]  = '{7'd73, 5'd2, 24'hFFFFFF, 24'hFFFFFE, 0, 24'h000001, 5,  24'h000002, 10, 24'h4,  15, 24'h8, 1, 17,  24'h00000E, 5'd3,  5'd3};
    vecs[4]  = '{7'd0,  5'd0, 24'hFFFFFF, 24'hFFFFFF, 0, 24'h000020, -1, 24'h000000, -1, 24'h0,  -1, 24'h0, 1, 2,   24'h000020, 5'd0,  5'd1};
    vecs[5]  = '{7'd10, 5'd24,24'hFFFFFF, 24'hFFFFFF, 0, 24'hFFFFFF, -1, 24'h000000, -1, 24'h0,  -1, 24'h0, 0, 0,   24'h000000, 5'd0,  5'd24};
    vecs[6]  = '{7'd10, 5'd23,24'hFFFFFF, 24'hFFFFFF, 0, 24'hFFFFFF, -1, 24'h000000, -1, 24'h0,  -1, 24'h0, 1, 2,   24'hFFFFFF, 5'd24, 5'd24};
    vecs[7]  = '{7'd127,5'd1, 24'hFFFFFF, 24'hFFFFFF, 0, 24'h000080, 127,24'h000100, -1, 24'h0,  -1, 24'h0, 1, 129, 24'h000180, 5'd1,  5'd2};
    vecs[8]  = '{7'd127,5'd1, 24'hFFFFFF, 24'hFFFFFF, 0, 24'h000080, 128,24'h000100, -1, 24'h0,  -1, 24'h0, 0, 0,   24'h000000, 5'd0,  5'd1};
    vecs[9]  = '{7'd5,  5'd1, 24'hFFFFFF, 24'hFFFFFF, 0, 24'h000001, 4,  24'h000001, 9,  24'h2,  -1, 24'h0, 1, 11,  24'h000003, 5'd1,  5'd2};
    vecs[10] = '{7'd73, 5'd2, 24'hFFFFFB, 24'hFFFFFF, 0, 24'h000001, 10, 24'h000002, 20, 24'h4,  -1, 24'h0, 0, 0,   24'h000000, 5'd0,  5'd2};

    rst_b          = 1'b0;
    srst           = 1'b0;
    u_if.i_trig    = 24'h0;
    u_if.i_enable  = 1'b1;
    u_if.i_inhibit = 1'b0;
    set_cfg(7'd0, 5'd0, 24'hFFFFFF, 24'hFFFFFF);
    tick();
    tick();
    chk("reset trig_o", 32'(u_if.o_trig), 32'd0);
    chk("reset chan_o", 32'(u_if.o_chan), 32'd0);
    chk("reset count_o", 32'(u_if.o_count), 32'd0);
    rst_b = 1'b1;
    run_cycles(3, n);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Inhibit held across a coincidence, then released
    set_cfg(7'd127, 5'd1, 24'hFFFFFF, 24'hFFFFFF);
    u_if.i_inhibit = 1'b1;
    u_if.i_trig    = 24'h3;
    tick();
    u_if.i_trig = 24'h0;
    n = u_if.o_trig ? 1 : 0;
    begin
      int k;
      run_cycles(49, k);
      n = n + k;
    end
    chk("inhibit no_trig", 32'(n), 32'd0);
    u_if.i_inhibit = 1'b0;
    tick();
    chk("inhibit release trig_o", 32'(u_if.o_trig), 32'd1);
    run_cycles(250, n);
    chk("inhibit single_pulse", 32'(n), 32'd0);
    u_if.i_trig = 24'h3;
    tick();
    u_if.i_trig = 24'h0;
    tick();
    tick();
    chk("hold back to idle retrigger", 32'(u_if.o_trig), 32'd1);
    run_cycles(200, n);

    // Reset mid-stretch with trigger levels held high
    set_cfg(7'd50, 5'd1, 24'hFFFFFF, 24'hFFFFFF);
    u_if.i_trig = 24'h3;
    run_cycles(10, n);
    chk("pre-reset trig", 32'(n), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("async reset count_o", 32'(u_if.o_count), 32'd0);
    chk("async reset chan_o", 32'(u_if.o_chan), 32'd0);
    chk("async reset trig_o", 32'(u_if.o_trig), 32'd0);
    run_cycles(3, n);
    rst_b = 1'b1;
    run_cycles(100, n);
    chk("post-reset no_trig", 32'(n), 32'd0);
    chk("post-reset count_o", 32'(u_if.o_count), 32'd0);
    u_if.i_trig = 24'h0;
    tick();
    u_if.i_trig = 24'h3;
    tick();
    chk("fresh edge latency1", 32'(u_if.o_trig), 32'd0);
    tick();
    tick();
    chk("fresh edge latency2", 32'(u_if.o_trig), 32'd1);
    u_if.i_trig = 24'h0;
    run_cycles(200, n);

    // Enable dropped mid-stretch
    u_if.i_trig = 24'h3;
    tick();
    u_if.i_trig = 24'h0;
    run_cycles(9, n);
    chk("enable pre trig", 32'(n), 32'd1);
    u_if.i_enable = 1'b0;
    tick();
    chk("disable count_o", 32'(u_if.o_count), 32'd0);
    chk("disable trig_o", 32'(u_if.o_trig), 32'd0);
    chk("disable chan_o hold", 32'(u_if.o_chan), 32'h3);
    u_if.i_enable = 1'b1;
    run_cycles(100, n);
    chk("reenable no_trig", 32'(n), 32'd0);
    chk("reenable count_o", 32'(u_if.o_count), 32'd0);

    // Channel losing qualification mid-stretch
    set_cfg(7'd50, 5'd2, 24'hFFFFFF, 24'hFFFFFF);
    u_if.i_trig = 24'h7;
    tick();
    u_if.i_trig = 24'h0;
    run_cycles(9, n);
    chk("qual pre trig", 32'(n), 32'd1);
    u_if.i_include = 24'hFFFFFE;
    tick();
    tick();
    chk("qual loss count_o", 32'(u_if.o_count), 32'd2);
    u_if.i_include = 24'hFFFFFF;
    run_cycles(100, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/radiant_trig_coinc.md
RADIANT_TRIG_COINC -- requirements
Module: radiant_trig_coinc

Interface
REQ-001 Parameter NCHAN, default 24: number of trigger channels.
REQ-002 Parameter WIN_BITS, default 7: width of coincidence window field.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 trig_i  input  NCHAN  per-channel discriminator levels, already synchronous to clk.
REQ-006 trig_en_i  input  NCHAN  global per-channel input enable.
REQ-007 include_i  input  NCHAN  per-channel inclusion mask for this coincidence trigger.
REQ-008 window_i  input  WIN_BITS  extra stretch clocks beyond the first.
REQ-009 thresh_i  input  5  coincidence threshold; trigger requires more than thresh_i active channels.
REQ-010 enable_i  input  1  block enable.
REQ-011 inhibit_i  input  1  downstream busy; suppresses new triggers.
REQ-012 trig_o  output  1  one-clock trigger pulse to the trigger overlord.
REQ-013 chan_o  output  NCHAN  stretched-channel pattern captured at the trig_o cycle.
REQ-014 count_o  output  5  registered count of active stretched channels.

Function
REQ-015 Channel i qualified = trig_en_i[i] AND include_i[i]; unqualified channels contribute 0 everywhere.
REQ-016 Rising edge = trig_i[i] high with previous-cycle registered trig_i[i] low.
REQ-017 On a qualified rising edge sampled at clock k, stretch[i] is high for exactly window_i+1 clocks starting at k.
REQ-018 A rising edge during an active stretch reloads the counter, extending to window_i+1 clocks from the new edge.
REQ-019 window_i = 0 gives a one-clock stretch; window_i maximum (127) gives 128 clocks.
REQ-020 count_o = popcount(stretch), registered one clock after stretch; saturating not needed (max 24 fits 5 bits).
REQ-021 FSM states: IDLE, HOLD.
REQ-022 IDLE: when count_o > thresh_i and inhibit_i low, assert trig_o for one clock, capture chan_o = stretch pattern of the same cycle count_o reflects, go HOLD.
REQ-023 Total latency: trig_o asserts 2 clocks after the clock at which the completing rising edge is sampled.
REQ-024 HOLD: trig_o low; return to IDLE only when count_o = 0 (all stretches expired), preventing retrigger on the same coincidence.
REQ-025 inhibit_i high in IDLE with coincidence: no trig_o, remain IDLE; trigger fires on first clock inhibit_i low if coincidence still present.
REQ-026 thresh_i >= NCHAN: block never triggers.
REQ-027 enable_i low: clear stretch counters, count_o, trig_o, force IDLE within one clock; chan_o holds last value.
REQ-028 Mask or window changes mid-stretch take effect on the next rising edge; a channel losing qualification clears its stretch next clock.

Reset
REQ-029 On rst_b low: stretch counters 0, edge registers 0, count_o 0, trig_o 0, chan_o 0, FSM IDLE.
REQ-030 Release of rst_b with trig_i high shall not produce a rising edge (edge registers initialise low only while trig_i low; first cycle after reset loads trig_i without edge detection).

Structure
REQ-031 Shared package radiant_trig_pkg holds NCHAN, WIN_BITS, FSM state typedef.
REQ-032 One sub-module radiant_trig_stretch (edge detect plus reloadable down-counter), instantiated NCHAN times.

Verification
REQ-033 window_i=73, thresh_i=2, all qualified; single-clock pulses on ch0, ch1, ch2 at clocks 0, 10, 20 -> one trig_o at clock 22, chan_o=0x000007, count_o=3.
REQ-034 Same setup, ch2 pulse at clock 80 -> ch0 expired (74 clocks), count peaks 2, no trig_o.
REQ-035 include_i=0xFFFFFE, pulses ch0, ch1, ch2 within window -> count 2, no trig_o; add ch3 -> trig_o, chan_o=0x00000E.
REQ-036 Coincidence held with inhibit_i high for 50 clocks -> no trig_o; inhibit_i low -> trig_o next clock, then HOLD until count_o 0, single pulse only.
REQ-037 rst_b asserted mid-stretch with trig_i held high -> outputs 0 immediately; after release no trig_o until a fresh rising edge.
REQ-038 window_i=0, thresh_i=0, pulse ch5 -> trig_o one clock, count_o returns to 0 next clock, FSM back to IDLE.
